// File: rtl/audio_ctrl_pkg.sv
// audio_ctrl_pkg
// Shared types and defaults for the audio player/recorder sequencer.
//   state_e       : FSM state encoding, also exported on o_state for display
//   ADDR_W_DEF    : default SRAM word address width
//   DATA_W_DEF    : default sample / SRAM data width
//   MAX_ADDR_DEF  : default last writable SRAM address
//   is_play()     : true for the two playback states
package audio_ctrl_pkg;

    localparam int          ADDR_W_DEF   = 20;
    localparam int          DATA_W_DEF   = 16;
    localparam logic [19:0] MAX_ADDR_DEF = 20'hFFFFF;

    typedef enum logic [2:0] {
        ST_INIT       = 3'd0,
        ST_IDLE       = 3'd1,
        ST_REC        = 3'd2,
        ST_REC_PAUSE  = 3'd3,
        ST_PLAY       = 3'd4,
        ST_PLAY_PAUSE = 3'd5
    } state_e;

    function automatic logic is_play(input state_e s);
        return (s == ST_PLAY) || (s == ST_PLAY_PAUSE);
    endfunction

endpackage

// File: rtl/audio_ctrl_fsm_sram_port_mux.sv
// sram_port_mux
// Registered SRAM port shared by recorder writes and playback reads.
//   clk, rst_n   : clock, asynchronous active-low reset
//   state_nxt    : state the FSM enters this edge; selects the address source
//   rec_wr       : accept a recorder write this cycle
//   rec_addr/data: recorder write address and data
//   play_addr    : play pointer value for the coming cycle
//   play_rd      : capture read data for the player this cycle
//   sram_rdata   : combinational SRAM read data for the current sram_addr
//   sram_*       : registered SRAM address / write data / active-low write enable
//   play_data/valid : registered read-return to the player
module sram_port_mux
    import audio_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  state_e            state_nxt,
    input  logic              rec_wr,
    input  logic [ADDR_W-1:0] rec_addr,
    input  logic [DATA_W-1:0] rec_data,
    input  logic [ADDR_W-1:0] play_addr,
    input  logic              play_rd,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_we_n,
    output logic [DATA_W-1:0] play_data,
    output logic              play_valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_we_n  <= 1'b1;
            play_data  <= '0;
            play_valid <= 1'b0;
        end else begin
            // Write strobe lasts exactly one cycle per accepted sample.
            sram_we_n  <= ~rec_wr;
            play_valid <= play_rd;
            if (rec_wr) begin
                sram_addr  <= rec_addr;
                sram_wdata <= rec_data;
            end else if (is_play(state_nxt)) begin
                // Address is loaded with the next pointer so the SRAM already
                // presents the right word when the player asks for it.
                sram_addr <= play_addr;
            end
            if (play_rd) begin
                play_data <= sram_rdata;
            end
        end
    end

endmodule

// File: rtl/audio_ctrl_fsm.sv
// audio_ctrl_fsm
// Sequencer for the audio player/recorder: turns key pulses and the mode
// switch into recorder start/pause/stop control, owns the shared SRAM port
// and tracks the recorded length so playback ends at the last valid sample.
//   i_clk, i_rst_n            : clock, asynchronous active-low reset
//   i_init_done               : codec init complete (level)
//   i_key_start/pause/stop    : one-cycle key pulses, priority stop > pause > start
//   i_mode_rec                : 1 = record, 0 = play; only looked at in IDLE
//   o_rec_start/o_rec_stop    : one-cycle pulses to the recorder
//   o_rec_pause               : level, high while recording is paused
//   i_rec_addr/data/wr_valid  : recorder write request
//   i_play_next               : player requests next sample
//   o_play_data/o_play_valid  : sample returned to the player
//   o_sram_*, i_sram_rdata    : shared SRAM port (read data combinational)
//   o_state                   : current state encoding
//   o_rec_len                 : number of samples recorded (saturating)
module audio_ctrl_fsm
    import audio_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MAX_ADDR_DEF)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_init_done,
    input  logic              i_key_start,
    input  logic              i_key_pause,
    input  logic              i_key_stop,
    input  logic              i_mode_rec,
    output logic              o_rec_start,
    output logic              o_rec_pause,
    output logic              o_rec_stop,
    input  logic [ADDR_W-1:0] i_rec_addr,
    input  logic [DATA_W-1:0] i_rec_data,
    input  logic              i_rec_wr_valid,
    input  logic              i_play_next,
    output logic [DATA_W-1:0] o_play_data,
    output logic              o_play_valid,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_wdata,
    output logic              o_sram_we_n,
    input  logic [DATA_W-1:0] i_sram_rdata,
    output logic [2:0]        o_state,
    output logic [ADDR_W-1:0] o_rec_len
);

    state_e            state, state_nxt;
    logic [ADDR_W-1:0] play_ptr, play_ptr_nxt, rec_len_nxt;
    logic              full_pend, full_pend_nxt;
    logic              key_start, key_pause, key_stop;
    logic              rec_wr, play_rd, play_last;
    logic [ADDR_W:0]   len_sum;
    logic [ADDR_W-1:0] len_sat;

    // Only the highest-priority key of a coincident group is considered.
    assign key_stop  = i_key_stop;
    assign key_pause = i_key_pause & ~i_key_stop;
    assign key_start = i_key_start & ~i_key_pause & ~i_key_stop;

    // Length after a write is addr+1, clamped to all-ones when it overflows.
    assign len_sum   = {1'b0, i_rec_addr} + (ADDR_W+1)'(1);
    assign len_sat   = len_sum[ADDR_W] ? '1 : len_sum[ADDR_W-1:0];
    assign play_last = (play_ptr == o_rec_len - ADDR_W'(1));

    assign o_state   = state;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: begin
                if (i_init_done) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (key_start) begin
                    if (i_mode_rec)              state_nxt = ST_REC;
                    else if (o_rec_len != '0)    state_nxt = ST_PLAY;
                end
            end
            ST_REC: begin
                if (key_stop || full_pend)       state_nxt = ST_IDLE;
                else if (key_pause)              state_nxt = ST_REC_PAUSE;
            end
            ST_REC_PAUSE: begin
                if (key_stop)                    state_nxt = ST_IDLE;
                else if (key_start)              state_nxt = ST_REC;
            end
            ST_PLAY: begin
                if (key_stop)                    state_nxt = ST_IDLE;
                else if (key_pause)              state_nxt = ST_PLAY_PAUSE;
                else if (i_play_next && play_last) state_nxt = ST_IDLE;
            end
            ST_PLAY_PAUSE: begin
                if (key_stop)                    state_nxt = ST_IDLE;
                else if (key_start)              state_nxt = ST_PLAY;
            end
            default: state_nxt = ST_INIT;
        endcase

        // A write is taken only if we stay in REC, so the strobe never
        // appears in any other state (also drops writes during the
        // auto-stop drain cycle).
        rec_wr        = (state == ST_REC) && (state_nxt == ST_REC) && i_rec_wr_valid;
        play_rd       = (state == ST_PLAY) && i_play_next && !key_stop && !key_pause;
        full_pend_nxt = rec_wr && (i_rec_addr == MAX_ADDR);

        rec_len_nxt = o_rec_len;
        if ((state == ST_IDLE) && (state_nxt == ST_REC)) rec_len_nxt = '0;
        else if (rec_wr)                                 rec_len_nxt = len_sat;

        // Pointer restarts at 0 whenever playback is entered or left.
        play_ptr_nxt = '0;
        if (is_play(state) && is_play(state_nxt))
            play_ptr_nxt = play_rd ? play_ptr + ADDR_W'(1) : play_ptr;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_INIT;
            full_pend   <= 1'b0;
            play_ptr    <= '0;
            o_rec_len   <= '0;
            o_rec_start <= 1'b0;
            o_rec_pause <= 1'b0;
            o_rec_stop  <= 1'b0;
        end else begin
            state       <= state_nxt;
            full_pend   <= full_pend_nxt;
            play_ptr    <= play_ptr_nxt;
            o_rec_len   <= rec_len_nxt;
            o_rec_start <= (state == ST_IDLE) && (state_nxt == ST_REC);
            o_rec_pause <= (state_nxt == ST_REC_PAUSE);
            o_rec_stop  <= ((state == ST_REC) || (state == ST_REC_PAUSE)) &&
                           (state_nxt == ST_IDLE);
        end
    end

    sram_port_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_sram_port_mux (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .state_nxt  (state_nxt),
        .rec_wr     (rec_wr),
        .rec_addr   (i_rec_addr),
        .rec_data   (i_rec_data),
        .play_addr  (play_ptr_nxt),
        .play_rd    (play_rd),
        .sram_rdata (i_sram_rdata),
        .sram_addr  (o_sram_addr),
        .sram_wdata (o_sram_wdata),
        .sram_we_n  (o_sram_we_n),
        .play_data  (o_play_data),
        .play_valid (o_play_valid)
    );

endmodule

// File: tb/tb_audio_ctrl_fsm.sv
// tb_audio_ctrl_fsm
// Bench for audio_ctrl_fsm with a 3-bit address space (MAX_ADDR=7) so the
// full/saturation corner is reachable. SRAM writes and playback samples are
// checked against scoreboard queues; the record control path is table-driven.
module tb_audio_ctrl_fsm;

    localparam int AW = 3;
    localparam int DW = 16;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_init_done, i_key_start, i_key_pause, i_key_stop, i_mode_rec;
    logic          o_rec_start, o_rec_pause, o_rec_stop;
    logic [AW-1:0] i_rec_addr;
    logic [DW-1:0] i_rec_data;
    logic          i_rec_wr_valid, i_play_next;
    logic [DW-1:0] o_play_data;
    logic          o_play_valid;
    logic [AW-1:0] o_sram_addr;
    logic [DW-1:0] o_sram_wdata;
    logic          o_sram_we_n;
    logic [DW-1:0] i_sram_rdata;
    logic [2:0]    o_state;
    logic [AW-1:0] o_rec_len;

    audio_ctrl_fsm #(.ADDR_W(AW), .DATA_W(DW), .MAX_ADDR(3'd7)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_init_done(i_init_done),
        .i_key_start(i_key_start), .i_key_pause(i_key_pause), .i_key_stop(i_key_stop),
        .i_mode_rec(i_mode_rec), .o_rec_start(o_rec_start), .o_rec_pause(o_rec_pause),
        .o_rec_stop(o_rec_stop), .i_rec_addr(i_rec_addr), .i_rec_data(i_rec_data),
        .i_rec_wr_valid(i_rec_wr_valid), .i_play_next(i_play_next),
        .o_play_data(o_play_data), .o_play_valid(o_play_valid),
        .o_sram_addr(o_sram_addr), .o_sram_wdata(o_sram_wdata), .o_sram_we_n(o_sram_we_n),
        .i_sram_rdata(i_sram_rdata), .o_state(o_state), .o_rec_len(o_rec_len)
    );

    always #5 i_clk = ~i_clk;

    // SRAM model: synchronous write, combinational read
    logic [DW-1:0] mem [0:7];
    assign i_sram_rdata = mem[o_sram_addr];
    always @(posedge i_clk) if (!o_sram_we_n) mem[o_sram_addr] <= o_sram_wdata;

    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    wr_t           wr_q[$];
    logic [DW-1:0] rd_q[$];
    wr_t           wr_e;
    logic [DW-1:0] rd_e;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitors, sampled on the falling edge
    always @(negedge i_clk) begin
        if (i_rst_n === 1'b1) begin
            if (o_sram_we_n === 1'b0) begin
                if (wr_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
                else begin
                    wr_e = wr_q.pop_front();
                    chk("wr_addr", 32'(o_sram_addr), 32'(wr_e.a));
                    chk("wr_data", 32'(o_sram_wdata), 32'(wr_e.d));
                    chk("wr_in_rec", 32'(o_state), 32'd2);
                end
            end
            if (o_play_valid === 1'b1) begin
                if (rd_q.size() == 0) chk("unexpected_play_valid", 32'd1, 32'd0);
                else begin
                    rd_e = rd_q.pop_front();
                    chk("play_data", 32'(o_play_data), 32'(rd_e));
                end
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic key(input logic s, input logic p, input logic t);
        i_key_start = s; i_key_pause = p; i_key_stop = t;
        tick();
        i_key_start = 1'b0; i_key_pause = 1'b0; i_key_stop = 1'b0;
    endtask

    typedef struct {
        logic       st, ps, sp, md, wr;
        logic [2:0] e_state;
        logic       e_start, e_pause, e_stop, e_we_n;
        logic [2:0] e_len;
    } vec_t;
    vec_t vt [13];

    function automatic vec_t mk(input int st, ps, sp, md, wr, es, est, eps, esp, ewe, el);
        vec_t v;
        v.st = st[0]; v.ps = ps[0]; v.sp = sp[0]; v.md = md[0]; v.wr = wr[0];
        v.e_state = es[2:0]; v.e_start = est[0]; v.e_pause = eps[0];
        v.e_stop = esp[0]; v.e_we_n = ewe[0]; v.e_len = el[2:0];
        return v;
    endfunction

    initial begin
        logic [DW-1:0] d;
        //          st ps sp md wr  state start pause stop we_n len
        vt[0]  = mk(1, 0, 0, 1, 0,  2, 1, 0, 0, 1, 0);  // start record, len cleared
        vt[1]  = mk(0, 0, 0, 1, 1,  2, 0, 0, 0, 0, 6);  // write addr 5
        vt[2]  = mk(0, 1, 0, 1, 0,  3, 0, 1, 0, 1, 6);  // pause
        vt[3]  = mk(0, 0, 0, 0, 1,  3, 0, 1, 0, 1, 6);  // write ignored, mode change ignored
        vt[4]  = mk(1, 0, 0, 0, 0,  2, 0, 0, 0, 1, 6);  // resume
        vt[5]  = mk(1, 1, 0, 1, 0,  3, 0, 1, 0, 1, 6);  // pause beats start
        vt[6]  = mk(1, 0, 0, 1, 0,  2, 0, 0, 0, 1, 6);  // resume
        vt[7]  = mk(0, 1, 1, 1, 0,  1, 0, 0, 1, 1, 6);  // stop beats pause
        vt[8]  = mk(0, 0, 0, 1, 0,  1, 0, 0, 0, 1, 6);  // stop is one cycle
        vt[9]  = mk(1, 0, 0, 1, 0,  2, 1, 0, 0, 1, 0);  // new record clears len
        vt[10] = mk(0, 0, 1, 1, 0,  1, 0, 0, 1, 1, 0);  // stop with nothing recorded
        vt[11] = mk(1, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0);  // play with len 0 ignored
        vt[12] = mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0);

        i_rst_n = 1'b1; i_init_done = 1'b0; i_mode_rec = 1'b0;
        i_key_start = 1'b0; i_key_pause = 1'b0; i_key_stop = 1'b0;
        i_rec_addr = '0; i_rec_data = '0; i_rec_wr_valid = 1'b0; i_play_next = 1'b0;

        // ---- reset and init ----
        #2 i_rst_n = 1'b0;
        #1;
        chk("rst_state", 32'(o_state), 32'd0);
        chk("rst_we_n", 32'(o_sram_we_n), 32'd1);
        chk("rst_len", 32'(o_rec_len), 32'd0);
        chk("rst_addr", 32'(o_sram_addr), 32'd0);
        tick(); tick();
        i_rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            i_key_start = (i == 4);
            i_mode_rec  = 1'b1;
            tick();
            i_key_start = 1'b0;
            chk("init_hold", 32'(o_state), 32'd0);
        end
        chk("init_no_start", 32'(o_rec_start), 32'd0);
        i_init_done = 1'b1;
        tick();
        chk("init_to_idle", 32'(o_state), 32'd1);

        // ---- record 4 samples ----
        i_mode_rec = 1'b1;
        key(1, 0, 0);
        chk("rec_state", 32'(o_state), 32'd2);
        chk("rec_start_pulse", 32'(o_rec_start), 32'd1);
        tick();
        chk("rec_start_one", 32'(o_rec_start), 32'd0);
        for (int i = 0; i < 4; i++) begin
            d = 16'hA000 + 16'(i);
            i_rec_wr_valid = 1'b1; i_rec_addr = 3'(i); i_rec_data = d;
            wr_q.push_back('{3'(i), d});
            tick();
            i_rec_wr_valid = 1'b0;
            chk("rec_len_step", 32'(o_rec_len), 32'(i + 1));
            tick();
            chk("we_one_cycle", 32'(o_sram_we_n), 32'd1);
        end
        key(0, 0, 1);
        chk("stop_state", 32'(o_state), 32'd1);
        chk("stop_pulse", 32'(o_rec_stop), 32'd1);
        chk("stop_len", 32'(o_rec_len), 32'd4);
        tick();
        chk("stop_one", 32'(o_rec_stop), 32'd0);

        // ---- play back 4 samples, 5 requests ----
        i_mode_rec = 1'b0;
        key(1, 0, 0);
        chk("play_state", 32'(o_state), 32'd4);
        chk("play_addr0", 32'(o_sram_addr), 32'd0);
        i_play_next = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) rd_q.push_back(16'hA000 + 16'(i));
            tick();
        end
        i_play_next = 1'b0;
        chk("play_end_idle", 32'(o_state), 32'd1);
        tick();
        chk("play_drained", 32'(rd_q.size()), 32'd0);

        // ---- table-driven record control ----
        for (int i = 0; i < 13; i++) begin
            d = 16'hBE00 + 16'(i);
            i_key_start = vt[i].st; i_key_pause = vt[i].ps; i_key_stop = vt[i].sp;
            i_mode_rec = vt[i].md; i_rec_wr_valid = vt[i].wr;
            i_rec_addr = 3'd5; i_rec_data = d;
            if (!vt[i].e_we_n) wr_q.push_back('{3'd5, d});
            tick();
            i_key_start = 1'b0; i_key_pause = 1'b0; i_key_stop = 1'b0; i_rec_wr_valid = 1'b0;
            chk($sformatf("vec%0d_state", i), 32'(o_state), 32'(vt[i].e_state));
            chk($sformatf("vec%0d_start", i), 32'(o_rec_start), 32'(vt[i].e_start));
            chk($sformatf("vec%0d_pause", i), 32'(o_rec_pause), 32'(vt[i].e_pause));
            chk($sformatf("vec%0d_stop", i), 32'(o_rec_stop), 32'(vt[i].e_stop));
            chk($sformatf("vec%0d_we_n", i), 32'(o_sram_we_n), 32'(vt[i].e_we_n));
            chk($sformatf("vec%0d_len", i), 32'(o_rec_len), 32'(vt[i].e_len));
        end

        // ---- fill to MAX_ADDR: auto-stop and saturation ----
        i_mode_rec = 1'b1;
        key(1, 0, 0);
        chk("full_rec_state", 32'(o_state), 32'd2);
        for (int i = 0; i < 8; i++) begin
            d = 16'hC000 + 16'(i);
            i_rec_wr_valid = 1'b1; i_rec_addr = 3'(i); i_rec_data = d;
            wr_q.push_back('{3'(i), d});
            tick();
            chk("full_len", 32'(o_rec_len), (i < 7) ? 32'(i + 1) : 32'd7);
        end
        i_rec_wr_valid = 1'b0;
        chk("full_last_write_in_rec", 32'(o_state), 32'd2);
        chk("full_last_we", 32'(o_sram_we_n), 32'd0);
        tick();
        chk("full_auto_idle", 32'(o_state), 32'd1);
        chk("full_stop_pulse", 32'(o_rec_stop), 32'd1);
        chk("full_we_off", 32'(o_sram_we_n), 32'd1);
        tick();
        chk("full_stop_one", 32'(o_rec_stop), 32'd0);

        // ---- playback with pause/resume over saturated length (7) ----
        i_mode_rec = 1'b0;
        key(1, 0, 0);
        i_play_next = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rd_q.push_back(16'hC000 + 16'(i));
            tick();
        end
        i_play_next = 1'b0;
        key(0, 1, 0);
        chk("ppause_state", 32'(o_state), 32'd5);
        i_play_next = 1'b1;
        tick(); tick();
        i_play_next = 1'b0;
        chk("ppause_ptr_held", 32'(o_sram_addr), 32'd2);
        key(1, 0, 0);
        chk("presume_state", 32'(o_state), 32'd4);
        i_play_next = 1'b1;
        for (int i = 2; i < 7; i++) begin
            rd_q.push_back(16'hC000 + 16'(i));
            tick();
        end
        i_play_next = 1'b0;
        chk("pfull_end_idle", 32'(o_state), 32'd1);
        tick();

        // ---- async reset mid-PLAY ----
        key(1, 0, 0);
        i_play_next = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rd_q.push_back(16'hC000 + 16'(i));
            tick();
        end
        i_play_next = 1'b0;
        tick();
        chk("pre_rst_play", 32'(o_state), 32'd4);
        #2 i_rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(o_state), 32'd0);
        chk("arst_len", 32'(o_rec_len), 32'd0);
        chk("arst_play_data", 32'(o_play_data), 32'd0);
        chk("arst_play_valid", 32'(o_play_valid), 32'd0);
        chk("arst_addr", 32'(o_sram_addr), 32'd0);
        chk("arst_we_n", 32'(o_sram_we_n), 32'd1);
        i_rst_n = 1'b1;
        tick();
        chk("arst_reinit", 32'(o_state), 32'd1);
        tick();

        chk("wr_q_empty", 32'(wr_q.size()), 32'd0);
        chk("rd_q_empty", 32'(rd_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_ctrl_fsm.md
Name: audio_ctrl_fsm

Overview:
Top-level sequencer for the audio player/recorder datapath. It turns debounced user key pulses and the record/play mode switch into start/pause/stop control for the recorder (AudRecorder). It also owns the shared SRAM port, muxing recorder writes and playback reads, and tracks the recorded length so playback stops at the end of valid data. Sits between the key/debounce logic, the codec-init block, AudRecorder and the playback DSP.

Parameters:
ADDR_W, 20, SRAM word address width
DATA_W, 16, sample/SRAM data width
MAX_ADDR, 20'hFFFFF, last writable SRAM address; recording auto-stops here

Ports:
i_clk  in  1  system clock; same clock as the recorder/player logic
i_rst_n  in  1  asynchronous active-low reset
i_init_done  in  1  codec I2C init complete (level)
i_key_start  in  1  start/resume pulse, one cycle
i_key_pause  in  1  pause pulse, one cycle
i_key_stop  in  1  stop pulse, one cycle
i_mode_rec  in  1  1 = record, 0 = play; sampled only in IDLE
o_rec_start  out  1  one-cycle start pulse to recorder
o_rec_pause  out  1  level, high while record paused
o_rec_stop  out  1  one-cycle stop pulse to recorder
i_rec_addr  in  ADDR_W  recorder write address
i_rec_data  in  DATA_W  recorder write data
i_rec_wr_valid  in  1  recorder write strobe, one cycle per sample
i_play_next  in  1  player requests next sample, one cycle
o_play_data  out  DATA_W  sample to player
o_play_valid  out  1  one-cycle, o_play_data valid
o_sram_addr  out  ADDR_W  SRAM address
o_sram_wdata  out  DATA_W  SRAM write data
o_sram_we_n  out  1  SRAM write enable, active low
i_sram_rdata  in  DATA_W  SRAM read data, combinational from o_sram_addr
o_state  out  3  current state encoding, for display
o_rec_len  out  ADDR_W  number of samples recorded

Behaviour:
- Reset (async, any state): state=INIT; o_rec_start=0, o_rec_pause=0, o_rec_stop=0, o_play_valid=0, o_play_data=0, o_sram_addr=0, o_sram_wdata=0, o_sram_we_n=1, o_rec_len=0, play pointer=0.
- All outputs are registered.
- States and encoding: INIT=0, IDLE=1, REC=2, REC_PAUSE=3, PLAY=4, PLAY_PAUSE=5.
- INIT -> IDLE on the first cycle with i_init_done=1. All keys are ignored in INIT.
- Key priority when pulses coincide: stop > pause > start.
- IDLE + start, i_mode_rec=1: go to REC; o_rec_start pulses 1 cycle; o_rec_len cleared to 0.
- IDLE + start, i_mode_rec=0, o_rec_len!=0: go to PLAY; play pointer=0.
- IDLE + start, i_mode_rec=0, o_rec_len==0: ignored; stay IDLE.
- REC + pause -> REC_PAUSE (o_rec_pause=1). REC_PAUSE + start -> REC (o_rec_pause=0).
- REC or REC_PAUSE + stop -> IDLE; o_rec_stop pulses 1 cycle; o_rec_pause=0.
- REC write path:
  - each i_rec_wr_valid at cycle N drives o_sram_addr=i_rec_addr, o_sram_wdata=i_rec_data, o_sram_we_n=0 at N+1 only;
  - o_rec_len <= i_rec_addr+1 at N+1.
  - i_rec_wr_valid is ignored in every state other than REC.
- Auto-stop on full: a write with i_rec_addr==MAX_ADDR completes, o_rec_len=MAX_ADDR+1 saturates to all-ones, then the FSM goes to IDLE with an o_rec_stop pulse the next cycle.
- PLAY read path:
  - o_sram_addr=play pointer, o_sram_we_n=1.
  - i_play_next at N: o_play_data <= i_sram_rdata, o_play_valid=1 at N+1, pointer++.
  - After the sample at pointer == o_rec_len-1 is delivered, go to IDLE.
- PLAY + pause -> PLAY_PAUSE. While paused, i_play_next is ignored and the pointer is held. PLAY_PAUSE + start -> PLAY.
- PLAY or PLAY_PAUSE + stop -> IDLE; pointer=0.
- i_mode_rec changes outside IDLE have no effect.
- Keys with no defined transition in the current state are ignored.
- o_sram_we_n is never low outside REC.

Decomposition:
- Package audio_ctrl_pkg: state enum (3-bit, values above), ADDR_W/DATA_W defaults, MAX_ADDR constant.
- One natural sub-module, sram_port_mux: registered address/data/we mux selected by state; it contains the write-capture and read-return registers.

Test Plan:
- Reset with i_init_done=0 for 10 cycles, then 1 -> o_state=0 while low, o_state=1 one cycle after; i_key_start during INIT ignored.
- Mode=1, start, 4 i_rec_wr_valid with addr 0..3, data 16'hA000..A003 -> 4 single-cycle o_sram_we_n=0 writes with matching addr/data; stop -> o_rec_stop 1 cycle, o_rec_len=4, o_state=1.
- Mode=0, start, 5 i_play_next pulses with SRAM model holding A000..A003 -> o_play_valid 4 times with A000..A003, then o_state=1; 5th pulse produces no valid.
- Recording: pause mid-record -> o_rec_pause=1 and i_rec_wr_valid produces no write; start resumes; simultaneous pause+stop -> IDLE with o_rec_stop pulse.
- Playback: play with o_rec_len=0 -> stays IDLE; MAX_ADDR=7 build recording 8 samples -> auto-stop, o_rec_len saturates, o_rec_stop pulse.
- Assert i_rst_n low mid-PLAY -> all outputs at reset values immediately (async), o_rec_len=0, o_state=0.
